// File: rtl/grn_sim_ctrl.sv
// Run controller for a dual-copy gene regulatory network simulator: steps a
// tortoise/hare pair until they meet, then measures the attractor period.
module grn_sim_ctrl #(
  parameter int N         = 8,
  parameter int CNT_W     = 16,
  parameter int MAX_STEPS = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [N-1:0]     cfg_init,
  input  logic [N-1:0]     s0_vec,
  input  logic [N-1:0]     s1_vec,
  output logic             reset_nos,
  output logic             start_s0,
  output logic             start_s1,
  output logic [N-1:0]     init_state,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_steps,
  output logic [CNT_W-1:0] res_period,
  output logic             res_timeout,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RUN    = 3'd2,
    PERIOD = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] step_cnt, step_nxt;
  logic [CNT_W-1:0] per_cnt, per_nxt;
  logic [N-1:0]     init_nxt;
  logic [CNT_W-1:0] res_steps_nxt, res_period_nxt;
  logic             res_timeout_nxt;
  logic             vec_eq, meet, peq;

  // Tortoise only moves on alternate strobes, so the copies can only be
  // compared meaningfully after an even, non-zero number of hare steps.
  assign vec_eq = (s0_vec == s1_vec);
  assign meet   = (step_cnt != '0) && !step_cnt[0] && vec_eq;
  assign peq    = (per_cnt != '0) && vec_eq;

  // Result handshake: res_valid is high only in DONE; the result transfers on
  // the cycle res_valid && res_ready, and res_* / init_state stay frozen until then.
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      step_cnt    <= '0;
      per_cnt     <= '0;
      init_state  <= '0;
      res_steps   <= '0;
      res_period  <= '0;
      res_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      step_cnt    <= step_nxt;
      per_cnt     <= per_nxt;
      init_state  <= init_nxt;
      res_steps   <= res_steps_nxt;
      res_period  <= res_period_nxt;
      res_timeout <= res_timeout_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    step_nxt        = step_cnt;
    per_nxt         = per_cnt;
    init_nxt        = init_state;
    res_steps_nxt   = res_steps;
    res_period_nxt  = res_period;
    res_timeout_nxt = res_timeout;
    reset_nos       = 1'b0;
    start_s0        = 1'b0;
    start_s1        = 1'b0;
    // Strobes are suppressed while rst is high; the register block ignores
    // the next-state values in that cycle anyway.
    if (!rst) begin
      case (state)
        IDLE: begin
          if (start) begin
            init_nxt  = cfg_init;
            step_nxt  = '0;
            per_nxt   = '0;
            state_nxt = LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            state_nxt = IDLE;
          end else begin
            reset_nos = 1'b1;
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state_nxt = IDLE;
          end else if (meet) begin
            res_steps_nxt = step_cnt;
            per_nxt       = '0;
            state_nxt     = PERIOD;
          end else if (step_cnt >= MAX_CNT) begin
            res_steps_nxt   = step_cnt;
            res_period_nxt  = '0;
            res_timeout_nxt = 1'b1;
            state_nxt       = DONE;
          end else begin
            start_s0 = 1'b1;
            start_s1 = 1'b1;
            step_nxt = step_cnt + ONE;
          end
        end
        PERIOD: begin
          if (abort) begin
            state_nxt = IDLE;
          end else if (peq) begin
            res_period_nxt  = per_cnt;
            res_timeout_nxt = 1'b0;
            state_nxt       = DONE;
          end else if (per_cnt >= MAX_CNT) begin
            res_period_nxt  = '0;
            res_timeout_nxt = 1'b1;
            state_nxt       = DONE;
          end else begin
            start_s1 = 1'b1;
            per_nxt  = per_cnt + ONE;
          end
        end
        DONE: begin
          if (res_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
